// File: rtl/modn_count_tracker.sv
// modn_count_tracker: monitors the output of a mod-N up/down counter.
// It recovers the step direction, wrap events and a signed revolution count.
// It flags jumps and out-of-range codes.
//
// state | meaning
// IDLE  | waiting for the first in-range sample after reset
// TRACK | prev holds a trusted sample; classify each new one against it
// FAULT | last sample was a jump or out of range; resync on next legal code
module modn_count_tracker #(
  parameter int N  = 10,
  parameter int W  = 4,
  parameter int RW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W-1:0]         count_in,
  output logic                 step,
  output logic                 dir_up,
  output logic                 dir_valid,
  output logic                 hold,
  output logic                 wrap_up,
  output logic                 wrap_dn,
  output logic                 err_jump,
  output logic                 err_range,
  output logic                 fault,
  output logic                 err_sticky,
  output logic signed [RW-1:0] rev_cnt
);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  localparam logic [W:0] CODE_N   = (W+1)'(N);
  localparam logic [W:0] CODE_TOP = (W+1)'(N - 1);
  localparam logic signed [RW-1:0] REV_MAX = {1'b0, {(RW-1){1'b1}}};
  localparam logic signed [RW-1:0] REV_MIN = {1'b1, {(RW-1){1'b0}}};

  state_t       state;
  logic [W-1:0] prev;

  // One extra bit keeps prev+1 from aliasing onto small codes near 2**W-1.
  logic [W:0] cur_x, prev_x, prev_inc, prev_dec;
  logic       in_range, is_same, is_inc, is_wup, is_dec, is_wdn;

  assign cur_x    = {1'b0, count_in};
  assign prev_x   = {1'b0, prev};
  assign prev_inc = prev_x + (W+1)'(1);
  assign prev_dec = prev_x - (W+1)'(1);
  assign in_range = cur_x < CODE_N;
  assign is_same  = cur_x == prev_x;
  assign is_inc   = (cur_x == prev_inc) && (prev_x < CODE_TOP);
  assign is_wup   = (prev_x == CODE_TOP) && (cur_x == '0);
  assign is_dec   = (cur_x == prev_dec) && (prev_x != '0);
  assign is_wdn   = (prev_x == '0) && (cur_x == CODE_TOP);

  // Sequencer: classify each sample and register all flags and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      step       <= 1'b0;
      dir_up     <= 1'b0;
      dir_valid  <= 1'b0;
      hold       <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_dn    <= 1'b0;
      err_jump   <= 1'b0;
      err_range  <= 1'b0;
      fault      <= 1'b0;
      err_sticky <= 1'b0;
      rev_cnt    <= '0;
    end else begin
      step      <= 1'b0;
      hold      <= 1'b0;
      wrap_up   <= 1'b0;
      wrap_dn   <= 1'b0;
      err_jump  <= 1'b0;
      err_range <= 1'b0;
      case (state)
        IDLE: begin
          if (in_range) begin
            prev  <= count_in;
            state <= TRACK;
          end else begin
            err_range  <= 1'b1;
            err_sticky <= 1'b1;
          end
        end
        TRACK: begin
          if (!in_range) begin
            err_range  <= 1'b1;
            err_sticky <= 1'b1;
            fault      <= 1'b1;
            dir_valid  <= 1'b0;
            state      <= FAULT;
          end else begin
            prev <= count_in;
            if (is_same) begin
              hold <= 1'b1;
            end else if (is_inc || is_wup) begin
              step      <= 1'b1;
              dir_up    <= 1'b1;
              dir_valid <= 1'b1;
              if (is_wup) begin
                wrap_up <= 1'b1;
                if (rev_cnt != REV_MAX) rev_cnt <= rev_cnt + RW'(1);
              end
            end else if (is_dec || is_wdn) begin
              step      <= 1'b1;
              dir_up    <= 1'b0;
              dir_valid <= 1'b1;
              if (is_wdn) begin
                wrap_dn <= 1'b1;
                if (rev_cnt != REV_MIN) rev_cnt <= rev_cnt - RW'(1);
              end
            end else begin
              err_jump   <= 1'b1;
              err_sticky <= 1'b1;
              fault      <= 1'b1;
              dir_valid  <= 1'b0;
              state      <= FAULT;
            end
          end
        end
        FAULT: begin
          if (!in_range) begin
            err_range  <= 1'b1;
            err_sticky <= 1'b1;
          end else begin
            prev  <= count_in;
            fault <= 1'b0;
            state <= TRACK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
